cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates between the instruction-cache and data-cache miss ports for the single physical-memory line port, one 128-bit line transaction at a time. Sits between the split L1 caches and physical memory (or L2). Grants one requester, latches its command, drives memory until the response arrives, then routes read data and a one-cycle response back. Arbitration is round-robin on contention, so neither pipeline stage starves.

## Interface
Parameters:
- none; widths come from `lc3b_types` (`lc3b_word` = 16 b address, `mem_bus` = 128 b line)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_read`  in  1  I-cache line read request; held high until `i_resp`
- `i_address`  in  16  I-cache miss address
- `i_rdata`  out  128  line returned to I-cache
- `i_resp`  out  1  one-cycle completion pulse to I-cache
- `d_read`  in  1  D-cache line read request; held until `d_resp`
- `d_write`  in  1  D-cache line writeback request; held until `d_resp`
- `d_address`  in  16  D-cache miss or writeback address
- `d_wdata`  in  128  D-cache writeback line
- `d_rdata`  out  128  line returned to D-cache
- `d_resp`  out  1  one-cycle completion pulse to D-cache
- `mem_read`  out  1  memory read strobe, held for the whole transaction
- `mem_write`  out  1  memory write strobe, held for the whole transaction
- `mem_address`  out  16  line-aligned address, bits [3:0] forced to 0
- `mem_wdata`  out  128  write line
- `mem_rdata`  in  128  read line, valid when `mem_resp` is high
- `mem_resp`  in  1  memory completion, one cycle

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- **IDLE**
  - `ireq = i_read`; `dreq = d_read | d_write`.
  - Only `ireq`: go to SERVE_I.
  - Only `dreq`: go to SERVE_D.
  - Both: grant the port opposite `last_grant`, where `last_grant` is a 1-bit register (0 = I, 1 = D).
  - On the grant edge, latch address (bits [3:0] cleared), write data and operation into command registers, and update `last_grant`.
- **SERVE_x**
  - Drive `mem_read` or `mem_write` from the latched command.
  - Later changes on the requester inputs are ignored.
  - On `mem_resp`:
    - pulse `x_resp` the same cycle;
    - drive `x_rdata = mem_rdata` (read) or 0 (write);
    - go to DONE.
- **DONE**
  - One dead cycle; all `mem_*` strobes and both `*_resp` low.
  - Go to IDLE.
  - The dead cycle lets the requester drop its request, so a stale request is never re-granted.
- D-cache with `d_read` and `d_write` both high is illegal; the write wins.
- `mem_read` and `mem_write` are never high together.
- The response pulse goes only to the granted port. The other `*_resp` stays 0.
- `i_rdata` and `d_rdata` are 0 whenever their `*_resp` is low.
- A `mem_resp` outside a SERVE state is ignored.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = D, so I wins the first tie after reset;
  - all outputs 0: `mem_read`, `mem_write`, `mem_address`, `mem_wdata`, `i_resp`, `d_resp`, `i_rdata`, `d_rdata`;
  - command registers 0.
- Request seen in IDLE at cycle 0. `mem_read` or `mem_write` is high from cycle 1.
- `mem_resp` at cycle N (N ≥ 1). `x_resp` is high in cycle N only (combinational pass of `mem_resp`).
- DONE in cycle N+1. Earliest next grant on the N+1 edge; next `mem_*` strobe in cycle N+2.
- Minimum transaction: 3 cycles from request to earliest next strobe when memory answers in 1 cycle.
- Back-to-back contention alternates grants I, D, I, D, …
- Reset asserted mid-transaction:
  - returns to IDLE on that edge with all outputs 0;
  - the in-flight memory response is dropped;
  - requesters must re-issue.
- A request arriving during SERVE or DONE waits. It is sampled in the next IDLE cycle.

## Test plan
1. **Reset, then lone I read.** Reset, then `i_read=1`, `i_address=16'h123A`.
   - `mem_read` high from cycle 1 with `mem_address=16'h1230`.
   - Memory returns `mem_rdata=128'hDEAD…BEEF` at cycle 4.
   - `i_resp=1` with that data in cycle 4 only; `d_resp=0`; DONE in cycle 5.
2. **Lone D writeback.** `d_write=1`, `d_address=16'h8004`, `d_wdata=128'hA5…A5`.
   - `mem_write=1`, `mem_address=16'h8000`, `mem_wdata=128'hA5…A5`.
   - `d_resp` pulses with `d_rdata=0`.
3. **First tie after reset.** `i_read` and `d_read` both raised in the same cycle.
   - I is served first.
   - D is granted on the DONE→IDLE path; its strobe appears 2 cycles after `i_resp`.
   - Repeat the tie: order is D then I.
4. **Illegal D command, then input churn.** `d_read=d_write=1`.
   - Only `mem_write` asserts.
   - Change `d_address` mid-transaction: `mem_address` stays at the latched value.
5. **Reset mid-transaction.** Assert `reset` during SERVE_D before `mem_resp`.
   - Next cycle all outputs are 0 and state is IDLE.
   - A later `mem_resp` pulse produces no `*_resp`.
6. **Stray memory response.** `mem_resp` high while in IDLE with no requests.
   - No `*_resp`; no state change.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one 128-bit memory line port between the I-cache and D-cache.
module cache_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_read,
    input  logic [15:0]  i_address,
    output logic [127:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_address,
    input  logic [127:0] d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [15:0]  mem_address,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_e;

    state_e       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         write_q, write_d;
    logic [15:0]  addr_q, addr_d;
    logic [127:0] wdata_q, wdata_d;
    logic         ireq, dreq, pick_d, serving;

    assign ireq    = i_read;
    assign dreq    = d_read | d_write;
    assign pick_d  = dreq & (~ireq | ~last_grant_q);
    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    assign mem_read    = serving & ~write_q;
    assign mem_write   = serving & write_q;
    assign mem_address = serving ? addr_q : 16'h0;
    assign mem_wdata   = serving ? wdata_q : 128'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            addr_q       <= 16'h0;
            wdata_q      <= 128'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // DONE arbitrates like IDLE: requesters drop on the resp edge, so only fresh requests are seen here
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = 128'h0;
        d_rdata      = 128'h0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (ireq || dreq) begin
                    state_d      = pick_d ? SERVE_D : SERVE_I;
                    last_grant_d = pick_d;
                    write_d      = pick_d & d_write;
                    addr_d       = {(pick_d ? d_address[15:4] : i_address[15:4]), 4'h0};
                    wdata_d      = (pick_d & d_write) ? d_wdata : 128'h0;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = write_q ? 128'h0 : mem_rdata;
                    state_d = DONE;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = write_q ? 128'h0 : mem_rdata;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and random stimulus; a transaction-level model predicts memory commands
// and responses, and a separate monitor checks every response pulse against the scoreboard queue.
module tb_cache_arbiter;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_resp = 1'b0;
    logic [15:0]  i_address = 16'h0, d_address = 16'h0;
    logic [127:0] d_wdata = 128'h0, mem_rdata = 128'h0;
    logic [127:0] i_rdata, d_rdata, mem_wdata;
    logic         i_resp, d_resp, mem_read, mem_write;
    logic [15:0]  mem_address;

    int           tests = 0, fails = 0;
    int           mem_lat = 3;
    logic         force_resp = 1'b0;
    logic [127:0] rdata_fix = 128'hDEAD_0011_2233_4455_6677_8899_AABB_BEEF;

    typedef struct packed {
        logic         port;
        logic [127:0] data;
    } resp_t;
    resp_t exp_q[$];

    cache_arbiter dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_strobes_resps"}, {mem_read, mem_write, i_resp, d_resp}, 0);
        chk({pfx, "_mem_address"}, mem_address, 0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 0);
        chk({pfx, "_i_rdata"}, i_rdata, 0);
        chk({pfx, "_d_rdata"}, d_rdata, 0);
    endtask

    // Called right after a negedge check: stray mem_resp next cycle, then confirm nothing moved
    task automatic stray(input string pfx);
        force_resp = 1'b1;
        cyc();
        @(negedge clk);
        chk({pfx, "_stray_resps"}, {i_resp, d_resp}, 0);
        chk({pfx, "_stray_rdata"}, i_rdata | d_rdata, 0);
        force_resp = 1'b0;
        cyc();
        @(negedge clk);
        chk({pfx, "_stray_strobes"}, {mem_read, mem_write}, 0);
    endtask

    // Memory: answers a held strobe after mem_lat extra cycles (random when negative)
    initial begin : mem_model
        int cnt;
        int lat;
        cnt = 0;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp  = force_resp;
            mem_rdata = force_resp ? rdata_fix : 128'h0;
            if (mem_read || mem_write) begin
                if (cnt == 0) lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                if (cnt == lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = (mem_lat < 0) ? {$urandom(), $urandom(), $urandom(), $urandom()} : rdata_fix;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Reference: one transaction at a time, a quiet cycle after each reply, ties go to whoever was not served last
    initial begin : ref_model
        logic         busy, last, wr, who;
        logic [15:0]  addr;
        logic [127:0] wd;
        busy = 1'b0; last = 1'b1; wr = 1'b0; who = 1'b0; addr = 16'h0; wd = 128'h0;
        forever begin
            @(posedge clk);
            #2;
            chk("mem_read", mem_read, busy && !wr);
            chk("mem_write", mem_write, busy && wr);
            if (busy) chk("mem_address", mem_address, addr);
            if (busy && wr) chk("mem_wdata", mem_wdata, wd);
            if (busy) begin
                if (mem_resp) begin
                    exp_q.push_back(resp_t'{who, wr ? 128'h0 : mem_rdata});
                    busy = 1'b0;
                end
            end else if (i_read || d_read || d_write) begin
                if (i_read && (d_read || d_write)) who = !last;
                else who = !i_read;
                last = who;
                busy = 1'b1;
                wr   = who && d_write;
                addr = (who ? d_address : i_address) & 16'hFFF0;
                wd   = d_wdata;
            end
            if (reset) begin
                busy = 1'b0;
                last = 1'b1;
            end
        end
    end

    initial begin : resp_monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b, none expected", i_resp, d_resp);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_i_port", i_resp, !e.port);
                    chk("resp_d_port", d_resp, e.port);
                    chk("resp_rdata", e.port ? d_rdata : i_rdata, e.data);
                end
            end
            if (exp_q.size() != 0) begin
                tests++;
                fails++;
                $display("FAIL missing_resp: %0d expected response(s) not pulsed", exp_q.size());
                exp_q.delete();
            end
            if (!i_resp) chk("i_rdata_idle", i_rdata, 0);
            if (!d_resp) chk("d_rdata_idle", d_rdata, 0);
        end
    end

    initial begin : stimulus
        logic [127:0] w4;
        logic         ir, dr;
        int           iw, dw, maxw, op;
        iw = 0; dw = 0; maxw = 0;
        // 1: reset, lone I read answered in cycle 4
        cyc(2);
        @(negedge clk);
        chk_quiet("reset");
        cyc(); reset = 1'b0; i_read = 1'b1; i_address = 16'h123A;
        @(negedge clk); chk("t1_c0_mem_read", mem_read, 0);
        cyc(); @(negedge clk);
        chk("t1_c1_mem_read", mem_read, 1);
        chk("t1_c1_mem_address", mem_address, 16'h1230);
        cyc(2); @(negedge clk); chk("t1_c3_i_resp", i_resp, 0);
        cyc(); @(negedge clk);
        chk("t1_c4_i_resp", i_resp, 1);
        chk("t1_c4_i_rdata", i_rdata, 128'hDEAD_0011_2233_4455_6677_8899_AABB_BEEF);
        chk("t1_c4_d_resp", d_resp, 0);
        mem_lat = 0;
        cyc(); i_read = 1'b0;
        @(negedge clk); chk("t1_c5_done", {mem_read, i_resp}, 0);
        // 2: lone D writeback
        cyc(2); d_write = 1'b1; d_address = 16'h8004; d_wdata = {16{8'hA5}};
        cyc(); @(negedge clk);
        chk("t2_strobes", {mem_read, mem_write}, 2'b01);
        chk("t2_mem_address", mem_address, 16'h8000);
        chk("t2_mem_wdata", mem_wdata, {16{8'hA5}});
        chk("t2_resps", {i_resp, d_resp}, 2'b01);
        chk("t2_d_rdata", d_rdata, 0);
        cyc(); d_write = 1'b0;
        // 3: tie after reset goes to I; I re-requests at once, so the next tie goes D then I
        cyc(2); i_read = 1'b1; i_address = 16'h2228; d_read = 1'b1; d_address = 16'h3339;
        cyc(); @(negedge clk);
        chk("t3_first_addr", mem_address, 16'h2220);
        chk("t3_first_resps", {i_resp, d_resp}, 2'b10);
        cyc(); i_address = 16'h444C;
        @(negedge clk); chk("t3_dead_cycle", {mem_read, mem_write}, 0);
        cyc(); @(negedge clk);
        chk("t3_second_strobe", mem_read, 1);
        chk("t3_second_addr", mem_address, 16'h3330);
        chk("t3_second_resps", {i_resp, d_resp}, 2'b01);
        cyc(); d_read = 1'b0;
        cyc(); @(negedge clk);
        chk("t3_third_addr", mem_address, 16'h4440);
        chk("t3_third_resps", {i_resp, d_resp}, 2'b10);
        mem_lat = 3;
        cyc(); i_read = 1'b0;
        // 4: read+write together acts as a write; input churn is ignored
        w4 = {$urandom(), $urandom(), $urandom(), $urandom()};
        cyc(2); d_read = 1'b1; d_write = 1'b1; d_address = 16'h5557; d_wdata = w4;
        cyc(); @(negedge clk);
        chk("t4_strobes", {mem_read, mem_write}, 2'b01);
        chk("t4_addr_c1", mem_address, 16'h5550);
        cyc(); d_address = 16'hFFFF; d_write = 1'b0;
        cyc(); @(negedge clk);
        chk("t4_addr_held", mem_address, 16'h5550);
        chk("t4_wdata_held", mem_wdata, w4);
        chk("t4_still_write", {mem_read, mem_write}, 2'b01);
        cyc(); @(negedge clk);
        chk("t4_d_resp", d_resp, 1);
        chk("t4_d_rdata", d_rdata, 0);
        mem_lat = 50;
        cyc(); d_read = 1'b0;
        // 5: reset during SERVE_D, then a late memory response
        cyc(2); d_read = 1'b1; d_address = 16'h6660;
        cyc(); @(negedge clk); chk("t5_strobe", mem_read, 1);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; d_read = 1'b0;
        @(negedge clk);
        chk_quiet("t5_after_reset");
        stray("t5");
        // 6: stray response while idle
        cyc(3); @(negedge clk);
        stray("t6");
        // Random traffic
        mem_lat = -1;
        repeat (3000) begin
            @(negedge clk);
            ir = i_resp;
            dr = d_resp;
            cyc();
            if (i_read && ir) i_read = 1'b0;
            else if (!i_read && $urandom_range(0, 2) == 0) begin
                i_read = 1'b1;
                i_address = 16'($urandom());
            end
            if ((d_read || d_write) && dr) begin
                d_read = 1'b0;
                d_write = 1'b0;
            end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
                op = int'($urandom_range(0, 4));
                d_read = (op < 2) || (op == 4);
                d_write = op >= 2;
                d_address = 16'($urandom());
                d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            iw = i_read ? iw + 1 : 0;
            dw = (d_read || d_write) ? dw + 1 : 0;
            maxw = (iw > maxw) ? iw : (dw > maxw) ? dw : maxw;
        end
        repeat (50) begin
            @(negedge clk);
            ir = i_resp;
            dr = d_resp;
            cyc();
            if (ir) i_read = 1'b0;
            if (dr) begin
                d_read = 1'b0;
                d_write = 1'b0;
            end
        end
        chk("random_drained", {i_read, d_read, d_write}, 0);
        chk("random_no_starvation", maxw < 30, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
